ksa_swap: RTL
=============

Name: ksa_swap

Overview:
- Second phase of the RC4 key-scheduling algorithm (KSA). Runs directly after the S-array identity fill (S[i]=i), against the same 256x8 single-port S RAM.
- For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- Produces the keyed permutation that the PRGA/decrypt stage consumes.
- Started by a start/done handshake from the top-level scheduler.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes; legal range 1..8.
- N, 256, S-array depth; fixed at 256, 8-bit indices.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  level-sampled in IDLE; begins a KSA pass
- secret_key  input  KEY_BYTES*8  key; byte 0 = most-significant byte
- mem_addr  output  8  S RAM address
- mem_wdata  output  8  S RAM write data
- mem_wren  output  1  S RAM write enable
- mem_rdata  input  8  S RAM read data, synchronous read
- ksa_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state) forces:
  - state=IDLE; i=0, j=0, k=0.
  - mem_addr=0, mem_wdata=0, mem_wren=0, ksa_done=0.
  - S RAM contents are not restored; a new identity fill must precede the next start.
- Outputs are decoded from state and registers only. mem_wren is high only in WRITE_I and WRITE_J.
- States per iteration, 6 cycles:
  - READ_I: mem_addr=i.
  - WAIT_I: mem_addr=i. On exit: si<=mem_rdata; j<=j+mem_rdata+key_byte[k] (8-bit wrap).
  - READ_J: mem_addr=j.
  - WAIT_J: mem_addr=j. On exit: sj<=mem_rdata.
  - WRITE_I: mem_addr=i, mem_wdata=sj, mem_wren=1.
  - WRITE_J: mem_addr=j, mem_wdata=si, mem_wren=1.
    - If i==255, go to DONE.
    - Otherwise i<=i+1, k<=(k==KEY_BYTES-1)?0:k+1, go to READ_I.
- Read timing: the address is held for two cycles and data is sampled on the edge leaving WAIT_x. This fits an address-registered, output-unregistered RAM.
- IDLE:
  - On start=1: secret_key is captured into key_r, and i, j, k are cleared to 0. Next state is READ_I.
  - Later changes on secret_key are ignored until the next start.
- DONE: ksa_done=1 for exactly one cycle, then IDLE.
- Latency: the edge sampling start is edge 0. The edge 1536 enters DONE, so ksa_done is high in the cycle after edge 1536.
- start is ignored in all states except IDLE.
  - If start is still high when IDLE is re-entered, a new pass begins on the next edge (back-to-back allowed).
- i==j: both writes target the same address with the same value. The end result is an unchanged entry; no special case is needed.
- Key byte selection uses the wrapping counter k, with no divider. key_byte[k] = key_r[(KEY_BYTES-1-k)*8 +: 8].

Optional Feature:
- KSA_DEBUG_EN
  - Defined: adds outputs dbg_i[7:0] (current i), dbg_j[7:0] (current j) and dbg_busy (1 in any state other than IDLE/DONE). These are used to drive LEDs/HEX and SignalTap.
  - Undefined: these ports do not exist, and core behaviour and timing are identical.

Decomposition:
- Package rc4_pkg:
  - RC4_N=256.
  - RC4_KEY_BYTES_DEFAULT=3.
  - typedef enum ksa_state_t {IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, DONE}.
  - typedef logic [7:0] rc4_byte_t.
- One sub-module, ksa_key_sel: holds key_r, the k counter with KEY_BYTES wrap, and outputs the current key byte. Load/advance are controlled by the FSM.

Test Plan:
- Identity-filled RAM, key 24'h000000, start pulse:
  - Iteration i=2 writes addr2<-3 then addr3<-2.
  - Final RAM matches a software RC4 KSA model.
- Key 24'h000249, start at edge 0:
  - ksa_done high for exactly 1 cycle, after edge 1536.
  - mem_wren high in exactly 512 cycles.
  - Final RAM equals the model.
- Key 24'h000000, i=0 iteration:
  - j=0, so both WRITE cycles drive addr0<-0.
  - S[0] unchanged after the iteration.
- start held high continuously:
  - A second pass begins on the edge after DONE.
  - A key change during the first pass does not affect its result.
  - start pulses while busy have no effect.
- Assert reset_n low at cycle 700 mid-run:
  - mem_wren=0, ksa_done=0, mem_addr=0 immediately.
  - After re-fill and start, the result matches the model.
- KEY_BYTES=1, key 8'hA5:
  - k stays 0, so every iteration uses 8'hA5.
  - Final RAM equals the model.

Source files
------------

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types and constants for the key-scheduling blocks
package rc4_pkg;

    localparam int RC4_N                 = 256;
    localparam int RC4_KEY_BYTES_DEFAULT = 3;

    typedef logic [7:0] rc4_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        READ_I,
        WAIT_I,
        READ_J,
        WAIT_J,
        WRITE_I,
        WRITE_J,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// rtl/ksa_key_sel.sv - captured secret key plus wrapping byte counter k
module ksa_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = RC4_KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   advance,
    input  logic [KEY_BYTES*8-1:0] key_in,
    output rc4_byte_t              key_byte
);

    localparam logic [2:0] K_LAST = 3'(KEY_BYTES - 1);

    logic [KEY_BYTES*8-1:0] key_r;
    logic [2:0]             k;
    rc4_byte_t              key_bytes [8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_r <= '0;
            k     <= '0;
        end else if (load) begin
            key_r <= key_in;
            k     <= '0;
        end else if (advance) begin
            k <= (k == K_LAST) ? 3'd0 : k + 3'd1;
        end
    end

    // Byte 0 is the most-significant byte of the key; unused slots read as zero.
    always_comb begin
        for (int b = 0; b < 8; b++) begin
            key_bytes[b] = '0;
        end
        for (int b = 0; b < KEY_BYTES; b++) begin
            key_bytes[b] = key_r[(KEY_BYTES-1-b)*8 +: 8];
        end
    end

    assign key_byte = key_bytes[k];

endmodule

// File: rtl/ksa_swap.sv
// rtl/ksa_swap.sv - RC4 KSA swap phase over a 256x8 single-port S RAM (optional KSA_DEBUG_EN taps)
module ksa_swap
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = RC4_KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    input  logic [7:0]             mem_rdata,
    output logic                   ksa_done
`ifdef KSA_DEBUG_EN
    ,
    output logic [7:0]             dbg_i,
    output logic [7:0]             dbg_j,
    output logic                   dbg_busy
`endif
);

    localparam rc4_byte_t I_LAST = rc4_byte_t'(RC4_N - 1);

    ksa_state_t state;
    rc4_byte_t  i;
    rc4_byte_t  j;
    rc4_byte_t  si;
    rc4_byte_t  key_byte;
    rc4_byte_t  j_next;
    logic       key_load;
    logic       key_adv;

    assign key_load = (state == IDLE) && start;
    assign key_adv  = (state == WRITE_J) && (i != I_LAST);
    assign j_next   = j + mem_rdata + key_byte;

    ksa_key_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (key_load),
        .advance  (key_adv),
        .key_in   (secret_key),
        .key_byte (key_byte)
    );

    // RAM outputs are registered alongside the state so each state presents
    // its address/data for the whole cycle; reads sample on leaving WAIT_x.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            si        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            ksa_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        mem_addr <= '0;
                        state    <= READ_I;
                    end
                end
                READ_I: state <= WAIT_I;
                WAIT_I: begin
                    si       <= mem_rdata;
                    j        <= j_next;
                    mem_addr <= j_next;
                    state    <= READ_J;
                end
                READ_J: state <= WAIT_J;
                WAIT_J: begin
                    mem_addr  <= i;
                    mem_wdata <= mem_rdata;
                    mem_wren  <= 1'b1;
                    state     <= WRITE_I;
                end
                WRITE_I: begin
                    mem_addr  <= j;
                    mem_wdata <= si;
                    state     <= WRITE_J;
                end
                WRITE_J: begin
                    mem_wren <= 1'b0;
                    if (i == I_LAST) begin
                        ksa_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        i        <= i + 8'd1;
                        mem_addr <= i + 8'd1;
                        state    <= READ_I;
                    end
                end
                DONE: begin
                    ksa_done  <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KSA_DEBUG_EN
    assign dbg_i    = i;
    assign dbg_j    = j;
    assign dbg_busy = (state != IDLE) && (state != DONE);
`endif

endmodule
